// File: rtl/divider_leg_if.sv
// divider_leg_if: carries the divided leg clock from the divider to its consumers.
interface divider_leg_if;
  logic clk_leg;
  modport master (output clk_leg);
  modport slave  (input  clk_leg);
endinterface

// File: rtl/divider_leg.sv
// divider_leg: divides clk by 2*HALF_PERIOD into a registered 50% square leg clock.
module divider_leg #(
  parameter int HALF_PERIOD = 5_000_000,
  parameter int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1
) (
  input  logic          clk,
  input  logic          reset,
  divider_leg_if.master leg_o
);
  if (HALF_PERIOD < 1) begin : g_bad_half_period
    $error("divider_leg: HALF_PERIOD must be at least 1");
  end
  localparam logic [CNT_W-1:0] TERM = CNT_W'(HALF_PERIOD - 1);
  logic [CNT_W-1:0] cnt_q = '0;
  logic [CNT_W-1:0] cnt_d;
  logic leg_q = 1'b0;
  logic leg_d;
  logic wrap;
  always_comb begin
    wrap  = cnt_q == TERM;
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    leg_d = wrap ? ~leg_q : leg_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      leg_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      leg_q <= leg_d;
    end
  end
  assign leg_o.clk_leg = leg_q;
endmodule

// File: tb/tb_divider_leg.sv
// tb_divider_leg: checks several divider_leg configurations against an edge-count model.
module tb_divider_leg;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int n = 0;
  always #5 clk = ~clk;
  always @(posedge clk) n <= reset ? 0 : n + 1;

  divider_leg_if if4 ();
  divider_leg_if if1 ();
  divider_leg_if if3 ();
  divider_leg_if if2 ();
  divider_leg_if ifd ();
  divider_leg #(.HALF_PERIOD(4)) dut4 (.clk(clk), .reset(reset), .leg_o(if4));
  divider_leg #(.HALF_PERIOD(1)) dut1 (.clk(clk), .reset(reset), .leg_o(if1));
  divider_leg #(.HALF_PERIOD(3)) dut3 (.clk(clk), .reset(reset), .leg_o(if3));
  divider_leg #(.HALF_PERIOD(2)) dut2 (.clk(clk), .reset(reset), .leg_o(if2));
  divider_leg dutd (.clk(clk), .reset(reset), .leg_o(ifd));

  typedef struct {
    bit rst;
    bit leg;
    int cnt;
  } vec_t;
  vec_t tbl[27];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (n=%0d t=%0t)", nm, act, exp, n, $time);
    end
  endtask

  // n counts non-reset edges since the last reset; every output follows from it
  task automatic check_all();
    chk("leg4", if4.clk_leg, (n / 4) % 2);
    chk("cnt4", dut4.cnt_q, n % 4);
    chk("leg1", if1.clk_leg, n % 2);
    chk("cnt1", dut1.cnt_q, 0);
    chk("leg3", if3.clk_leg, (n / 3) % 2);
    chk("cnt3", dut3.cnt_q, n % 3);
    chk("leg2", if2.clk_leg, (n / 2) % 2);
    chk("cnt2", dut2.cnt_q, n % 2);
    chk("legd", ifd.clk_leg, (n / 5_000_000) % 2);
    chk("cntd", dutd.cnt_q, n % 5_000_000);
  endtask

  initial begin
    int r4[$], f4[$], r3[$], f3[$];
    logic p4, p3;
    tbl = '{
      '{1'b1, 1'b0, 0}, '{1'b1, 1'b0, 0}, '{1'b1, 1'b0, 0},
      '{1'b0, 1'b0, 1}, '{1'b0, 1'b0, 2}, '{1'b0, 1'b0, 3}, '{1'b0, 1'b1, 0},
      '{1'b0, 1'b1, 1}, '{1'b0, 1'b1, 2}, '{1'b0, 1'b1, 3}, '{1'b0, 1'b0, 0},
      '{1'b0, 1'b0, 1}, '{1'b0, 1'b0, 2}, '{1'b0, 1'b0, 3}, '{1'b0, 1'b1, 0},
      '{1'b0, 1'b1, 1}, '{1'b0, 1'b1, 2},
      '{1'b1, 1'b0, 0},
      '{1'b0, 1'b0, 1}, '{1'b0, 1'b0, 2}, '{1'b0, 1'b0, 3}, '{1'b0, 1'b1, 0},
      '{1'b0, 1'b1, 1}, '{1'b0, 1'b1, 2}, '{1'b0, 1'b1, 3},
      '{1'b1, 1'b0, 0},
      '{1'b0, 1'b0, 1}
    };
    #1;
    check_all();
    for (int i = 0; i < 27; i++) begin
      reset = tbl[i].rst;
      @(negedge clk);
      chk($sformatf("tbl_leg[%0d]", i), if4.clk_leg, tbl[i].leg);
      chk($sformatf("tbl_cnt[%0d]", i), dut4.cnt_q, tbl[i].cnt);
      check_all();
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all();
    reset = 1'b0;
    p4 = 1'b0;
    p3 = 1'b0;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      check_all();
      if (if4.clk_leg && !p4) r4.push_back(k);
      if (!if4.clk_leg && p4) f4.push_back(k);
      if (if3.clk_leg && !p3) r3.push_back(k);
      if (!if3.clk_leg && p3) f3.push_back(k);
      p4 = if4.clk_leg;
      p3 = if3.clk_leg;
    end
    chk("rises4", r4.size(), 11);
    chk("falls4", f4.size(), 11);
    chk("rises3", r3.size(), 15);
    chk("falls3", f3.size(), 15);
    for (int i = 0; i < r4.size() && i < 11; i++) chk($sformatf("rise4[%0d]", i), r4[i], 4 + 8 * i);
    for (int i = 0; i < f4.size() && i < 11; i++) chk($sformatf("fall4[%0d]", i), f4[i], 8 + 8 * i);
    for (int i = 0; i < r3.size() && i < 15; i++) chk($sformatf("rise3[%0d]", i), r3[i], 3 + 6 * i);
    for (int i = 0; i < f3.size() && i < 15; i++) chk($sformatf("fall3[%0d]", i), f3[i], 6 + 6 * i);
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      check_all();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
